// File: rtl/sid_decim_pkg.sv
// Shared constants and helpers for the SID PDM-to-PCM decimator.
package sid_decim_pkg;

  localparam int CIC_ORDER    = 3;
  localparam int WARMUP_TICKS = 3;
  localparam int DC_SHIFT     = 8;

  // Every CIC stage can grow the magnitude by log2(DECIM) bits.
  function automatic int acc_width(input int decim);
    return 1 + CIC_ORDER * $clog2(decim);
  endfunction

  function automatic int out_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int out_min(input int w);
    return -(1 << (w - 1));
  endfunction

  function automatic int sat_signed(input int v, input int w);
    if (v > out_max(w)) return out_max(w);
    if (v < out_min(w)) return out_min(w);
    return v;
  endfunction

endpackage

// File: rtl/sid_dc_blocker.sv
// One-pole DC-removal high-pass, one sample in / one sample out, saturating to OUT_W.
module sid_dc_blocker
  import sid_decim_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [OUT_W-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [OUT_W-1:0] out_data_o
);

  localparam int IW = OUT_W + 2;
  localparam logic signed [IW-1:0] Y_MAX = IW'(out_max(OUT_W));
  localparam logic signed [IW-1:0] Y_MIN = IW'(out_min(OUT_W));

  logic signed [IW-1:0] x_prev_q, y_prev_q, x_ext, y_w;
  logic [OUT_W-1:0]     y_sat, out_data_q;
  logic                 out_valid_q;

  always_comb begin
    x_ext = $signed({{2{in_data_i[OUT_W-1]}}, in_data_i});
    y_w   = x_ext - x_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
    y_sat = y_w[OUT_W-1:0];
    if (y_w > Y_MAX)      y_sat = Y_MAX[OUT_W-1:0];
    else if (y_w < Y_MIN) y_sat = Y_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid_i;
      if (in_valid_i) begin
        x_prev_q   <= x_ext;
        y_prev_q   <= $signed({{2{y_sat[OUT_W-1]}}, y_sat});
        out_data_q <= y_sat;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/sid_pdm_decimator.sv
// 3rd-order CIC PDM-to-PCM decimator with valid/ready output.
// Optional DC-removal stage enabled by defining SID_DECIM_DC_BLOCK_EN.
module sid_pdm_decimator
  import sid_decim_pkg::*;
#(
  parameter int DECIM = 256,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_in,
  input  logic             pdm_en,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun
);

  localparam int ACC_W = acc_width(DECIM);
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [ACC_W-1:0] R_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic [ACC_W-1:0]     integ_q [CIC_ORDER];
  logic [ACC_W-1:0]     comb_q  [CIC_ORDER];
  logic [ACC_W-1:0]     hist_q  [CIC_ORDER];
  logic [CIC_ORDER-1:0] step_q, live_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           warm_q;
  logic                 tick, warm_done;
  logic [OUT_W-1:0]     scaled_w, scaled_q, fin_q, smp;
  logic                 scaled_v_q, fin_v_q, smp_v;
  logic [OUT_W-1:0]     data_q;
  logic                 valid_q, ovr_q;

  assign tick      = pdm_en && (cnt_q == CNT_W'(DECIM - 1));
  assign warm_done = (warm_q == 2'(WARMUP_TICKS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CIC_ORDER; i++) integ_q[i] <= '0;
      cnt_q  <= '0;
      warm_q <= '0;
    end else if (pdm_en) begin
      integ_q[0] <= integ_q[0] + ACC_W'(pdm_in);
      for (int i = 1; i < CIC_ORDER; i++) integ_q[i] <= integ_q[i] + integ_q[i-1];
      cnt_q <= cnt_q + CNT_W'(1);
      if (tick && !warm_done) warm_q <= warm_q + 2'd1;
    end
  end

  // step_q walks every tick through the combs so history stays primed during
  // warm-up; live_q marks only the ticks that will reach the output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        comb_q[i] <= '0;
        hist_q[i] <= '0;
      end
      step_q     <= '0;
      live_q     <= '0;
      scaled_q   <= '0;
      scaled_v_q <= 1'b0;
      fin_q      <= '0;
      fin_v_q    <= 1'b0;
    end else begin
      step_q[0] <= tick;
      live_q[0] <= tick && warm_done;
      if (tick) begin
        comb_q[0] <= integ_q[CIC_ORDER-1] - hist_q[0];
        hist_q[0] <= integ_q[CIC_ORDER-1];
      end
      for (int i = 1; i < CIC_ORDER; i++) begin
        step_q[i] <= step_q[i-1];
        live_q[i] <= live_q[i-1];
        if (step_q[i-1]) begin
          comb_q[i] <= comb_q[i-1] - hist_q[i];
          hist_q[i] <= comb_q[i-1];
        end
      end
      scaled_v_q <= live_q[CIC_ORDER-1];
      if (step_q[CIC_ORDER-1]) scaled_q <= scaled_w;
      fin_v_q <= scaled_v_q;
      fin_q   <= {~scaled_q[OUT_W-1], scaled_q[OUT_W-2:0]};
    end
  end

  // Full scale (DECIM^3) is the only value with the top bit set; clamp it.
  if (OUT_W <= ACC_W - 1) begin : g_slice
    assign scaled_w = (comb_q[CIC_ORDER-1] > R_MAX) ? '1
                    : comb_q[CIC_ORDER-1][ACC_W-2 -: OUT_W];
  end else begin : g_pad
    assign scaled_w = (comb_q[CIC_ORDER-1] > R_MAX) ? '1
                    : {comb_q[CIC_ORDER-1][ACC_W-2:0], {(OUT_W-ACC_W+1){1'b0}}};
  end

`ifdef SID_DECIM_DC_BLOCK_EN
  sid_dc_blocker #(.OUT_W(OUT_W)) u_dc_blocker (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (fin_v_q),
    .in_data_i  (fin_q),
    .out_valid_o(smp_v),
    .out_data_o (smp)
  );
`else
  assign smp_v = fin_v_q;
  assign smp   = fin_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (smp_v) begin
        if (!valid_q || pcm_ready) begin
          data_q  <= smp;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && pcm_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pcm_data  = data_q;
  assign pcm_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_sid_pdm_decimator.sv
// Self-checking bench for sid_pdm_decimator: vector table, hand sequences and random stimulus
// against a cycle-level model built from the CIC impulse response.
module tb_sid_pdm_decimator;

  localparam int D  = 256;
  localparam int OW = 16;
  localparam int AW = 25;
`ifdef SID_DECIM_DC_BLOCK_EN
  localparam int LAT   = 6;
  localparam bit DC_ON = 1'b1;
`else
  localparam int LAT   = 5;
  localparam bit DC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, pdm_in = 1'b0, pdm_en = 1'b0, pcm_ready = 1'b1;
  logic [OW-1:0] pcm_data;
  logic          pcm_valid, overrun;

  always #5 clk = ~clk;

  sid_pdm_decimator #(.DECIM(D), .OUT_W(OW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pdm_in   (pdm_in),
    .pdm_en   (pdm_en),
    .pcm_data (pcm_data),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overrun  (overrun)
  );

  typedef struct { int due; logic [OW-1:0] val; } pend_t;
  typedef struct { string name; int pattern; bit gated; logic [OW-1:0] exp_data; int n; } vec_t;

  int            n_checks = 0, n_fail = 0, cyc = 0;
  int            h [3*D-2];
  bit            bits [$];
  pend_t         pend [$];
  logic          m_valid = 1'b0, m_ovr = 1'b0;
  logic [OW-1:0] m_data = '0, first_exp = '0, vec_expect = '0;
  int            dc_xp = 0, dc_yp = 0;
  int            hs_run = 0, rise_run = 0, ovr_run = 0, last_rise = 0, burst = 0;
  int            tick4_cyc = -100000;
  bit            first_seen = 1'b0, vec_on = 1'b0, spacing_on = 1'b0;
  logic          prev_v = 1'b0;
  vec_t          vt [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  // CIC output for the k-th tick: weighted window of the accepted bits.
  function automatic logic [OW-1:0] model_sample(input int k);
    longint r = 0;
    longint rmax = (longint'(1) << (AW - 1)) - 1;
    int p = k * D - 4;
    logic [OW-1:0] s;
    for (int m = 0; m < 3*D-2; m++)
      if (p - m >= 0 && bits[p-m]) r += h[m];
    if (r > rmax) r = rmax;
    s = OW'(r >> (AW - 1 - OW));
    return s ^ 16'h8000;
  endfunction

  function automatic logic [OW-1:0] dc_model(input logic [OW-1:0] xu);
    int x, y;
    x = int'($signed(xu));
    y = x - dc_xp + dc_yp - (dc_yp >>> 8);
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    dc_xp = x;
    dc_yp = y;
    return OW'(y);
  endfunction

  // Advance one clock: update the model for the coming edge, then check the DUT after it.
  task automatic cycle();
    logic hs;
    logic [OW-1:0] v;
    int k;
    if (rst_n && pcm_valid === 1'b1 && pcm_ready) begin
      hs_run++;
      $display("txn %0d: pcm_data=%h cycle %0d", hs_run, pcm_data, cyc);
      if (vec_on) chk("vec_data", 32'(pcm_data), 32'(vec_expect));
    end
    if (!rst_n) begin
      bits.delete();
      pend.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
      dc_xp = 0; dc_yp = 0;
      tick4_cyc = -100000; first_seen = 1'b0;
    end else begin
      m_ovr = 1'b0;
      hs = m_valid && pcm_ready;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        if (!m_valid || hs) begin m_data = pend[0].val; m_valid = 1'b1; end
        else m_ovr = 1'b1;
        void'(pend.pop_front());
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (pdm_en) begin
        bits.push_back(pdm_in);
        if (bits.size() % D == 0) begin
          k = bits.size() / D;
          if (k >= 4) begin
            v = model_sample(k);
            if (DC_ON) v = dc_model(v);
            if (k == 4) begin tick4_cyc = cyc + 1; first_exp = v; end
            pend.push_back('{due: cyc + 1 + LAT, val: v});
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("valid", 32'(pcm_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("data", 32'(pcm_data), 32'(m_data));
    if (overrun === 1'b1) ovr_run++;
    if (pcm_valid === 1'b1 && prev_v !== 1'b1) begin
      rise_run++;
      if (!first_seen) begin
        chk("latency", cyc - tick4_cyc, LAT);
        first_seen = 1'b1;
      end else if (spacing_on) begin
        chk("spacing", cyc - last_rise, D);
      end
      last_rise = cyc;
    end
    prev_v = pcm_valid;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; pdm_in = 1'b1; pdm_en = 1'b1; pcm_ready = 1'b1;
    repeat (n) cycle();
    chk("rst_valid", 32'(pcm_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_data", 32'(pcm_data), 0);
    rst_n = 1'b1;
    hs_run = 0; rise_run = 0; ovr_run = 0;
  endtask

  // pat: 0 ones, 1 zeros, 2 alternating, 3 random
  task automatic feed_until(input int nbits, input int pat, input bit gated, input bit rnd_ready);
    int g = 0;
    while (bits.size() < nbits && g < nbits * 8) begin
      case (pat)
        0: pdm_in = 1'b1;
        1: pdm_in = 1'b0;
        2: pdm_in = (bits.size() % 2 == 0);
        default: pdm_in = 1'($urandom_range(0, 1));
      endcase
      pdm_en = gated ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd_ready) begin
        if (burst > 0) begin pcm_ready = 1'b0; burst--; end
        else if ($urandom_range(0, 15) == 0) begin pcm_ready = 1'b0; burst = $urandom_range(1, 40); end
        else pcm_ready = 1'b1;
      end
      cycle();
      g++;
    end
    if (bits.size() < nbits) chk("feed_timeout", bits.size(), nbits);
  endtask

  initial begin
    int b2 [2*D-1];
    foreach (b2[i]) b2[i] = 0;
    for (int a = 0; a < D; a++) for (int b = 0; b < D; b++) b2[a+b]++;
    foreach (h[m]) begin
      h[m] = 0;
      for (int c = 0; c < D; c++) if (m - c >= 0 && m - c < 2*D-1) h[m] += b2[m-c];
    end

    vt[0] = '{name: "ones",       pattern: 0, gated: 1'b0, exp_data: 16'h7FFF, n: 6};
    vt[1] = '{name: "zeros",      pattern: 1, gated: 1'b0, exp_data: 16'h8000, n: 6};
    vt[2] = '{name: "alternate",  pattern: 2, gated: 1'b0, exp_data: 16'h0000, n: 6};
    vt[3] = '{name: "ones_gated", pattern: 0, gated: 1'b1, exp_data: 16'h7FFF, n: 6};

    for (int v = 0; v < 4; v++) begin
      $display("vector %s", vt[v].name);
      do_reset(10);
      vec_expect = vt[v].exp_data;
      vec_on     = !DC_ON;
      spacing_on = !vt[v].gated;
      feed_until((3 + vt[v].n) * D, vt[v].pattern, vt[v].gated, 1'b0);
      pdm_en = 1'b0;
      repeat (LAT + 2) cycle();
      vec_on = 1'b0; spacing_on = 1'b0;
      chk({vt[v].name, "_count"}, hs_run, vt[v].n);
    end

    $display("sequence: enable gap");
    do_reset(3);
    feed_until(4*D + 100, 3, 1'b0, 1'b0);
    pdm_en = 1'b0;
    repeat (1000) cycle();
    chk("gap_quiet", rise_run, 1);
    feed_until(6*D, 3, 1'b0, 1'b0);
    pdm_en = 1'b0;
    repeat (LAT + 2) cycle();
    chk("gap_count", hs_run, 3);

    $display("sequence: backpressure");
    do_reset(3);
    pcm_ready = 1'b0;
    feed_until(5*D, 3, 1'b0, 1'b0);
    pdm_en = 1'b0;
    repeat (LAT + 2) cycle();
    chk("bp_overrun_count", ovr_run, 1);
    chk("bp_valid_held", 32'(pcm_valid), 1);
    chk("bp_data_held", 32'(pcm_data), 32'(first_exp));
    pcm_ready = 1'b1;
    repeat (10) cycle();
    chk("bp_handshakes", hs_run, 1);
    chk("bp_valid_clear", 32'(pcm_valid), 0);

    $display("sequence: reset mid-sample");
    do_reset(3);
    feed_until(5*D, 3, 1'b0, 1'b0);
    pdm_en = 1'b1;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rise_run = 0;
    feed_until(4*D - 1, 3, 1'b0, 1'b0);
    pdm_en = 1'b0;
    repeat (LAT + 2) cycle();
    chk("rst_mid_none", rise_run, 0);
    feed_until(4*D, 3, 1'b0, 1'b0);
    pdm_en = 1'b0;
    repeat (LAT + 2) cycle();
    chk("rst_mid_first", rise_run, 1);

    $display("sequence: random");
    do_reset(3);
    burst = 0;
    feed_until(15*D, 3, 1'b1, 1'b1);
    pdm_en = 1'b0;
    pcm_ready = 1'b1;
    repeat (LAT + 45) cycle();
    chk("rnd_count", hs_run, 12);
    chk("rnd_overrun", ovr_run, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sid_pdm_decimator.md
# sid_pdm_decimator

PDM-to-PCM decimation stage fed by the 1-bit PDM audio output (`uo_out[0]`) of `tt_um_sid`. It runs a 3rd-order CIC filter, decimates by `DECIM`, and delivers signed `OUT_W`-bit PCM samples over a valid/ready handshake. It is the in-system replacement for ad-hoc counting decimators, and it feeds an I2S/DAC serializer or a logging sink.

## Interface
- `DECIM`, 256: decimation ratio in accepted PDM samples; power of two, 16..1024.
- `OUT_W`, 16: PCM sample width, 8..24.
- `clk  in  1`: system clock, 5 MHz nominal.
- `rst_n  in  1`: reset, synchronous, active-low; clock `clk`.
- `pdm_in  in  1`: PDM bit; 1 = +full scale, 0 = −full scale.
- `pdm_en  in  1`: sample qualifier; `pdm_in` is consumed only in cycles with `pdm_en`=1.
- `pcm_data  out  OUT_W`: two's-complement PCM sample.
- `pcm_valid  out  1`: `pcm_data` holds an undelivered sample.
- `pcm_ready  in  1`: sink accepts the sample when `pcm_valid`&&`pcm_ready`.
- `overrun  out  1`: one-cycle pulse when a finished sample is dropped.

## Operation
- `ACC_W` = 1 + 3·log2(`DECIM`). This is 25 for the defaults. All CIC arithmetic is unsigned and wraps modulo 2^`ACC_W`.
- Integrators: three cascaded registered accumulators. Each one updates only when `pdm_en`=1. I1 += `pdm_in`, I2 += I1, I3 += I2.
- Decimation counter: 0..`DECIM`−1. It increments on each `pdm_en`. A tick is raised when the counter is at `DECIM`−1 with `pdm_en`=1, and the counter wraps to 0 on that tick.
- Comb: three pipelined stages, Cn = x − x_prev, each advancing one stage per clock after a tick. The comb history registers update only on ticks.
- Scaling: comb result R lies in [0, `DECIM`^3].
  - Saturate R to `DECIM`^3 − 1.
  - Take bits [`ACC_W`−2 : `ACC_W`−1−`OUT_W`].
  - Invert the MSB, converting offset binary to two's complement.
- Warm-up: a 2-bit counter discards the first 3 ticks after reset. No valid and no overrun are produced for them.
- Output register and handshake:
  - A finished sample loads when `pcm_valid`=0, or when `pcm_valid`&&`pcm_ready` in the same cycle; `pcm_valid` stays 1.
  - If `pcm_valid`=1 and `pcm_ready`=0, the new sample is dropped. The held sample is unchanged and `overrun` pulses.
  - A handshake with no new sample clears `pcm_valid`.
- While `pcm_valid`=1, `pcm_data` is stable until it is accepted.

## Timing
- Reset values: all accumulators, comb registers, counters, `pcm_data`, `pcm_valid` and `overrun` are 0.
- Reset applies on any edge with `rst_n`=0 and aborts in-flight samples. Warm-up restarts.
- Latency: the `pdm_en` edge that completes a tick to the `pcm_valid` rise is fixed.
  - 5 clocks without `SID_DECIM_DC_BLOCK_EN`.
  - 6 clocks with `SID_DECIM_DC_BLOCK_EN`.
  - Latency is independent of `pdm_en` gaps after the tick.
- With `pdm_en` held at 1, one sample is produced every `DECIM` clocks. The `pdm_en`=0 cycles stretch the period; they do not add samples.
- A tick, an acceptance and a fresh load can all occur in one cycle; this must be handled without loss.

## Configuration
- `SID_DECIM_DC_BLOCK_EN` defined:
  - A DC-removal high-pass is inserted after scaling: y = x − x_prev + y_prev − (y_prev >>> 8).
  - Internal width is `OUT_W`+2; the result saturates to `OUT_W`.
  - The filter adds one pipeline stage and updates once per sample.
- Undefined: the scaled sample goes straight to the output register.

## Structure
- Package `sid_decim_pkg` holds:
  - the `ACC_W` function of `DECIM`;
  - the CIC order constant (3);
  - the warm-up count (3);
  - the DC-block shift (8);
  - the `OUT_W` saturation helpers.
- Sub-module `sid_dc_blocker`: one-sample-in/one-sample-out high-pass with a valid strobe. It is instantiated only under `SID_DECIM_DC_BLOCK_EN`.
- The top contains the integrators, counters, comb pipeline, scaler and output handshake.

## Test plan
1. Reset check: drive `rst_n`=0 for 10 cycles with `pdm_in`=1. Required: `pcm_valid`=0, `overrun`=0, `pcm_data`=0.
2. Constant 1s: `pdm_in`=1, `pdm_en`=1, `pcm_ready`=1, DC block off. Required: the first valid arrives 5 clocks after the 4th tick. Every sample is 0x7FFF, and samples are spaced 256 clocks apart.
3. Constant 0s and alternating bits, DC block off:
   - `pdm_in`=0 gives 0x8000 on every sample.
   - Alternating 1010… gives 0x0000.
   - DC block on, constant 1s: output decays monotonically toward 0 and falls below 0x0100 within 2048 samples.
4. Gated input: after warm-up, hold `pdm_en`=0 for 1000 cycles, then resume. Required: no tick during the gap; the sample values are identical to an ungated run.
5. Backpressure: hold `pcm_ready`=0 across two ticks. Required: the first sample is held stable and `overrun` pulses once at the second sample. After raising ready, exactly one handshake occurs, then `pcm_valid`=0.
6. Reset mid-sample: assert `rst_n`=0 for one cycle, 3 clocks after a tick. Required: no `pcm_valid` from that tick, and the next 3 ticks are discarded.
